// File: rtl/i2c_state_pkg.sv
// rtl/i2c_state_pkg.sv - shared states and constants for the I2C subordinate controller
// One-hot state encoding, bit indices and reserved I2C address patterns.
package i2c_state_pkg;

  localparam int ST_IDLE      = 0;
  localparam int ST_ADDR1     = 1;
  localparam int ST_ACK_A1    = 2;
  localparam int ST_ADDR2     = 3;
  localparam int ST_ACK_A2    = 4;
  localparam int ST_RX        = 5;
  localparam int ST_ACK_RX    = 6;
  localparam int ST_TX        = 7;
  localparam int ST_MACK      = 8;
  localparam int ST_WAIT_STOP = 9;

  typedef enum logic [9:0] {
    S_IDLE      = 10'b1 << ST_IDLE,
    S_ADDR1     = 10'b1 << ST_ADDR1,
    S_ACK_A1    = 10'b1 << ST_ACK_A1,
    S_ADDR2     = 10'b1 << ST_ADDR2,
    S_ACK_A2    = 10'b1 << ST_ACK_A2,
    S_RX        = 10'b1 << ST_RX,
    S_ACK_RX    = 10'b1 << ST_ACK_RX,
    S_TX        = 10'b1 << ST_TX,
    S_MACK      = 10'b1 << ST_MACK,
    S_WAIT_STOP = 10'b1 << ST_WAIT_STOP
  } sub_ctrl_state_t;

  localparam logic [7:0] GCALL_ADDR  = 8'h00;
  localparam logic [4:0] TEN_BIT_HDR = 5'b11110;

endpackage

// File: rtl/i2c_addr_match.sv
// rtl/i2c_addr_match.sv - combinational own-address slot comparator
// General call takes precedence; otherwise the lowest matching slot wins.
module i2c_addr_match
  import i2c_state_pkg::*;
#(
  parameter int NUM_ADDR   = 2,
  parameter int TEN_BIT_EN = 1,
  parameter int GCALL_EN   = 1,
  parameter int MW         = 2
) (
  input  logic [7:0]             addr_byte,
  input  logic [NUM_ADDR*10-1:0] own_addr,
  input  logic [NUM_ADDR-1:0]    addr_10b,
  output logic                   hit,
  output logic [MW-1:0]          idx,
  output logic                   is10,
  output logic                   gcall
);

  always_comb begin
    hit   = 1'b0;
    idx   = '1;
    is10  = 1'b0;
    gcall = 1'b0;
    if (GCALL_EN != 0 && addr_byte == GCALL_ADDR) begin
      hit   = 1'b1;
      gcall = 1'b1;
    end else begin
      // Descending scan so the lowest matching slot overwrites the others.
      for (int i = NUM_ADDR - 1; i >= 0; i--) begin
        if (TEN_BIT_EN != 0 && addr_10b[i]) begin
          if (addr_byte[7:3] == TEN_BIT_HDR && addr_byte[2:1] == own_addr[10*i+8 +: 2]) begin
            hit  = 1'b1;
            idx  = i[MW-1:0];
            is10 = 1'b1;
          end
        end else if (addr_byte[7:1] == own_addr[10*i +: 7]) begin
          hit  = 1'b1;
          idx  = i[MW-1:0];
          is10 = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_sub_ctrl_multi.sv
// rtl/i2c_sub_ctrl_multi.sv - multi-address I2C subordinate protocol FSM
// Runs on the system clock from SCL edge strobes; all outputs are registered.
module i2c_sub_ctrl_multi
  import i2c_state_pkg::*;
#(
  parameter int NUM_ADDR    = 2,
  parameter int TEN_BIT_EN  = 1,
  parameter int GCALL_EN    = 1,
  parameter int STRETCH_MAX = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        scl_rise,
  input  logic                        scl_fall,
  input  logic                        sda_in,
  input  logic                        start_det,
  input  logic                        stop_det,
  input  logic [NUM_ADDR*10-1:0]      own_addr,
  input  logic [NUM_ADDR-1:0]         addr_10b,
  input  logic                        hold_req,
  input  logic                        nack_req,
  input  logic [7:0]                  tx_byte,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_byte,
  output logic                        rx_valid,
  output logic                        sda_low,
  output logic                        scl_low,
  output logic [$clog2(NUM_ADDR):0]   match_idx,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [9:0]                  state_onehot
);

  localparam int MW = $clog2(NUM_ADDR) + 1;
  localparam logic [9:0] SMAX = 10'(STRETCH_MAX);

  sub_ctrl_state_t state, state_nxt;
  logic [7:0]  shift, shift_nxt, rx_shift, slot_lo, rx_byte_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [9:0]  stretch_cnt, stretch_nxt;
  logic [MW-1:0] m_idx, m_idx_nxt, armed_idx, armed_idx_nxt, match_idx_nxt, am_idx;
  logic armed10, armed10_nxt, m_is10, m_is10_nxt, rw, rw_nxt, nack, nack_nxt;
  logic in_slot, in_slot_nxt, tx_pend, tx_pend_nxt, slot_nack, tx_start;
  logic sda_low_nxt, scl_low_nxt, rx_valid_nxt, tx_ready_nxt, timeout_nxt, busy_nxt;
  logic am_hit, am_is10, am_gcall;

  assign rx_shift     = {shift[6:0], sda_in};
  assign state_onehot = state;

  i2c_addr_match #(
    .NUM_ADDR  (NUM_ADDR),
    .TEN_BIT_EN(TEN_BIT_EN),
    .GCALL_EN  (GCALL_EN),
    .MW        (MW)
  ) u_addr_match (
    .addr_byte(rx_shift),
    .own_addr (own_addr),
    .addr_10b (addr_10b),
    .hit      (am_hit),
    .idx      (am_idx),
    .is10     (am_is10),
    .gcall    (am_gcall)
  );

  // Low byte of the slot matched by the 10-bit header, compared in ADDR2.
  always_comb begin
    slot_lo = '0;
    for (int i = 0; i < NUM_ADDR; i++)
      if (m_idx == i[MW-1:0]) slot_lo = own_addr[10*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;       shift <= '0;       bit_cnt <= '0;
      stretch_cnt <= '0;     m_idx <= '0;       armed_idx <= '0;
      armed10 <= 1'b0;       m_is10 <= 1'b0;    rw <= 1'b0;
      nack <= 1'b0;          in_slot <= 1'b0;   tx_pend <= 1'b0;
      sda_low <= 1'b0;       scl_low <= 1'b0;   rx_byte <= '0;
      rx_valid <= 1'b0;      tx_ready <= 1'b0;  timeout_err <= 1'b0;
      busy <= 1'b0;          match_idx <= '1;
    end else begin
      state <= state_nxt;    shift <= shift_nxt;  bit_cnt <= bit_cnt_nxt;
      stretch_cnt <= stretch_nxt; m_idx <= m_idx_nxt; armed_idx <= armed_idx_nxt;
      armed10 <= armed10_nxt; m_is10 <= m_is10_nxt; rw <= rw_nxt;
      nack <= nack_nxt;      in_slot <= in_slot_nxt; tx_pend <= tx_pend_nxt;
      sda_low <= sda_low_nxt; scl_low <= scl_low_nxt; rx_byte <= rx_byte_nxt;
      rx_valid <= rx_valid_nxt; tx_ready <= tx_ready_nxt; timeout_err <= timeout_nxt;
      busy <= busy_nxt;      match_idx <= match_idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;       shift_nxt = shift;     bit_cnt_nxt = bit_cnt;
    m_idx_nxt = m_idx;       armed_idx_nxt = armed_idx; armed10_nxt = armed10;
    m_is10_nxt = m_is10;     rw_nxt = rw;           nack_nxt = nack;
    in_slot_nxt = in_slot;   tx_pend_nxt = tx_pend; sda_low_nxt = sda_low;
    scl_low_nxt = scl_low;   rx_byte_nxt = rx_byte; match_idx_nxt = match_idx;
    rx_valid_nxt = 1'b0;     tx_ready_nxt = 1'b0;   timeout_nxt = 1'b0;
    stretch_nxt = scl_low ? stretch_cnt + 10'd1 : 10'd0;
    slot_nack = nack || (state == S_ACK_RX && nack_req);
    tx_start = 1'b0;

    if (!enable) begin
      state_nxt = S_IDLE; sda_low_nxt = 1'b0; scl_low_nxt = 1'b0; armed10_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt = S_ADDR1; bit_cnt_nxt = '0; sda_low_nxt = 1'b0; scl_low_nxt = 1'b0;
    end else if (stop_det) begin
      state_nxt = S_IDLE; sda_low_nxt = 1'b0; scl_low_nxt = 1'b0; armed10_nxt = 1'b0;
    end else if (scl_low && (stretch_cnt + 10'd1 == SMAX)) begin
      state_nxt = S_IDLE; sda_low_nxt = 1'b0; scl_low_nxt = 1'b0; timeout_nxt = 1'b1;
    end else begin
      unique case (state)
        S_ADDR1, S_ADDR2, S_RX: if (scl_rise) begin
          shift_nxt   = rx_shift;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            in_slot_nxt = 1'b0;
            nack_nxt    = 1'b0;
            if (state == S_RX) begin
              rx_byte_nxt = rx_shift; rx_valid_nxt = 1'b1; state_nxt = S_ACK_RX;
            end else if (state == S_ADDR2) begin
              if (rx_shift == slot_lo) begin
                state_nxt = S_ACK_A2; armed10_nxt = 1'b1; armed_idx_nxt = m_idx;
              end else state_nxt = S_WAIT_STOP;
            end else if (am_hit) begin
              state_nxt = S_ACK_A1; m_idx_nxt = am_idx; m_is10_nxt = am_is10;
              rw_nxt = rx_shift[0];
              match_idx_nxt = am_gcall ? '1 : am_idx;
              // A 10-bit read is only honoured after that slot was armed by a write.
              nack_nxt = am_is10 && rx_shift[0] && !(armed10 && armed_idx == am_idx);
            end else state_nxt = S_WAIT_STOP;
          end
        end
        S_ACK_A1, S_ACK_A2, S_ACK_RX: begin
          if (scl_low) begin
            if (!hold_req) scl_low_nxt = 1'b0;
          end else if (scl_fall) begin
            if (!in_slot) begin
              in_slot_nxt = 1'b1; nack_nxt = slot_nack;
              sda_low_nxt = !slot_nack; scl_low_nxt = hold_req;
            end else begin
              in_slot_nxt = 1'b0; sda_low_nxt = 1'b0; bit_cnt_nxt = '0;
              if (nack) state_nxt = S_WAIT_STOP;
              else if (state == S_ACK_A1 && m_is10 && !rw) state_nxt = S_ADDR2;
              else if (state == S_ACK_A1 && rw) tx_start = 1'b1;
              else state_nxt = S_RX;
            end
          end
        end
        S_TX: begin
          if (scl_low) begin
            if (tx_valid) tx_start = 1'b1;
          end else if (scl_fall) begin
            if (tx_pend) tx_start = 1'b1;
            else if (bit_cnt == 4'd7) begin
              sda_low_nxt = 1'b0; state_nxt = S_MACK;
            end else begin
              shift_nxt = {shift[6:0], 1'b0}; bit_cnt_nxt = bit_cnt + 4'd1;
              sda_low_nxt = ~shift[6];
            end
          end
        end
        S_MACK: if (scl_rise) begin
          if (!sda_in) begin state_nxt = S_TX; tx_pend_nxt = 1'b1; end
          else state_nxt = S_WAIT_STOP;
        end
        default: ;
      endcase

      // Byte start for transmit: load now, or hold SCL until the core has data.
      if (tx_start) begin
        state_nxt = S_TX; bit_cnt_nxt = '0; tx_pend_nxt = 1'b0;
        if (tx_valid) begin
          shift_nxt = tx_byte; sda_low_nxt = ~tx_byte[7];
          tx_ready_nxt = 1'b1; scl_low_nxt = 1'b0;
        end else begin
          sda_low_nxt = 1'b0; scl_low_nxt = 1'b1;
        end
      end
    end
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_i2c_sub_ctrl_multi.sv
// tb/tb_i2c_sub_ctrl_multi.sv - directed bench for i2c_sub_ctrl_multi
// Drives SCL/SDA strobes; received and transmitted bytes are checked through queues.
module tb_i2c_sub_ctrl_multi;

  localparam logic [9:0] ST_IDLE      = 10'b00_0000_0001;
  localparam logic [9:0] ST_ADDR1     = 10'b00_0000_0010;
  localparam logic [9:0] ST_RX        = 10'b00_0010_0000;
  localparam logic [9:0] ST_WAIT_STOP = 10'b10_0000_0000;

  logic clk = 1'b0, rst_n, enable, scl_rise, scl_fall, sda_in, start_det, stop_det;
  logic [19:0] own_addr;
  logic [1:0]  addr_10b;
  logic hold_req, nack_req, tx_valid;
  logic [7:0] tx_byte;
  logic tx_ready, rx_valid, sda_low, scl_low, busy, timeout_err;
  logic [7:0] rx_byte;
  logic [1:0] match_idx;
  logic [9:0] state_onehot;
  logic t_tx_ready, t_rx_valid, t_sda_low, t_scl_low, t_busy, t_timeout_err;
  logic [7:0] t_rx_byte;
  logic [1:0] t_match_idx;
  logic [9:0] t_state_onehot;

  int n_assert = 0, n_fail = 0;
  int rx_seen = 0, tx_seen = 0, to_main = 0, t_rx_seen = 0, t_tx_seen = 0, t_to_seen = 0;
  int tx_exp = 0, cnt;
  logic [7:0] rx_q[$], tx_q[$];
  logic ack, d;
  logic [7:0] b;

  always #5 clk = ~clk;

  i2c_sub_ctrl_multi dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .sda_in(sda_in), .start_det(start_det), .stop_det(stop_det), .own_addr(own_addr),
    .addr_10b(addr_10b), .hold_req(hold_req), .nack_req(nack_req), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .sda_low(sda_low), .scl_low(scl_low), .match_idx(match_idx), .busy(busy),
    .timeout_err(timeout_err), .state_onehot(state_onehot));

  i2c_sub_ctrl_multi #(.STRETCH_MAX(31)) dut_to (
    .clk(clk), .rst_n(rst_n), .enable(enable), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .sda_in(sda_in), .start_det(start_det), .stop_det(stop_det), .own_addr(own_addr),
    .addr_10b(addr_10b), .hold_req(hold_req), .nack_req(nack_req), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .tx_ready(t_tx_ready), .rx_byte(t_rx_byte), .rx_valid(t_rx_valid),
    .sda_low(t_sda_low), .scl_low(t_scl_low), .match_idx(t_match_idx), .busy(t_busy),
    .timeout_err(t_timeout_err), .state_onehot(t_state_onehot));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cond();
    start_det = 1'b1; tick(1); start_det = 1'b0;
  endtask

  task automatic stop_cond();
    stop_det = 1'b1; tick(1); stop_det = 1'b0; tick(1);
  endtask

  // One SCL period: data set while low, drv = sda_low seen before the rise.
  task automatic slot(input logic bit_v, output logic drv);
    sda_in = bit_v; tick(2); drv = sda_low;
    scl_rise = 1'b1; tick(1); scl_rise = 1'b0; tick(2);
    scl_fall = 1'b1; tick(1); scl_fall = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic acked);
    logic dv;
    for (int i = 7; i >= 0; i--) slot(v[i], dv);
    slot(1'b1, dv);
    acked = dv;
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic mack);
    logic dv;
    for (int i = 7; i >= 0; i--) begin
      slot(1'b1, dv);
      v[i] = ~dv;
    end
    slot(mack, dv);
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_seen++;
      chk("rx_expected", rx_q.size() != 0, 1);
      if (rx_q.size() != 0) chk("rx_byte", rx_byte, rx_q.pop_front());
    end
    if (tx_ready) tx_seen++;
    if (timeout_err) to_main++;
    if (t_rx_valid) t_rx_seen++;
    if (t_tx_ready) t_tx_seen++;
    if (t_timeout_err) t_to_seen++;
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; scl_rise = 1'b0; scl_fall = 1'b0; sda_in = 1'b1;
    start_det = 1'b0; stop_det = 1'b0; hold_req = 1'b0; nack_req = 1'b0;
    tx_byte = 8'h00; tx_valid = 1'b0;
    own_addr = {10'h03A, 10'h2B5};
    addr_10b = 2'b01;
    tick(3); rst_n = 1'b1; tick(1);
    chk("reset_state", state_onehot, ST_IDLE);
    chk("reset_busy", busy, 0);
    chk("reset_match_idx", match_idx, 2'b11);
    chk("reset_lines", {sda_low, scl_low}, 0);

    // 7-bit write to slot 1
    start_cond();
    send_byte(8'h74, ack); chk("w7_addr_ack", ack, 1);
    chk("w7_match_idx", match_idx, 1);
    rx_q.push_back(8'h5C);
    send_byte(8'h5C, ack); chk("w7_data_ack", ack, 1);
    chk("w7_state_rx", state_onehot, ST_RX);
    stop_cond();
    chk("w7_stop_idle", state_onehot, ST_IDLE);
    chk("w7_stop_busy", busy, 0);

    // 10-bit write header, low byte, repeated START, read header
    tx_byte = 8'hC3; tx_valid = 1'b1; tx_q.push_back(8'hC3); tx_exp++;
    start_cond();
    send_byte(8'hF4, ack); chk("t10_hdr_ack", ack, 1);
    send_byte(8'hB5, ack); chk("t10_lo_ack", ack, 1);
    start_cond();
    send_byte(8'hF5, ack); chk("t10_rd_ack", ack, 1);
    recv_byte(b, 1'b1); chk("t10_tx_byte", b, tx_q.pop_front());
    chk("t10_nack_wait", state_onehot, ST_WAIT_STOP);
    stop_cond();
    tx_valid = 1'b0;

    // general call write; read of address 0 is not acknowledged
    start_cond();
    send_byte(8'h00, ack); chk("gc_ack", ack, 1);
    chk("gc_match_idx", match_idx, 2'b11);
    chk("gc_state_rx", state_onehot, ST_RX);
    stop_cond();
    start_cond();
    send_byte(8'h01, ack); chk("gc_rd_noack", ack, 0);
    chk("gc_rd_wait", state_onehot, ST_WAIT_STOP);
    stop_cond();

    // transmit stretch: data arrives 40 clk late; the 31-cycle instance times out
    tx_byte = 8'h96; tx_valid = 1'b0; tx_q.push_back(8'h96); tx_exp++;
    start_cond();
    send_byte(8'h75, ack); chk("st_addr_ack", ack, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (scl_low) cnt++;
      if (i == 39) tx_valid = 1'b1;
      tick(1);
    end
    chk("st_hold_cycles", cnt, 40);
    chk("st_released", scl_low, 0);
    chk("st_to_pulses", t_to_seen, 1);
    chk("st_to_busy", t_busy, 0);
    chk("st_to_scl", t_scl_low, 0);
    recv_byte(b, 1'b1); chk("st_tx_byte", b, tx_q.pop_front());
    stop_cond();

    // core NACK on the second received byte
    start_cond();
    send_byte(8'h74, ack); chk("nk_addr_ack", ack, 1);
    rx_q.push_back(8'h11);
    send_byte(8'h11, ack); chk("nk_b1_ack", ack, 1);
    nack_req = 1'b1; rx_q.push_back(8'h22);
    send_byte(8'h22, ack); chk("nk_b2_nack", ack, 0);
    nack_req = 1'b0;
    chk("nk_wait", state_onehot, ST_WAIT_STOP);
    stop_cond();
    chk("nk_idle", state_onehot, ST_IDLE);

    // START during transmit bit 3; armed 10-bit slot survives the START
    tx_byte = 8'h00; tx_valid = 1'b1; tx_exp++;
    start_cond();
    send_byte(8'hF4, ack); send_byte(8'hB5, ack);
    start_cond();
    send_byte(8'hF5, ack); chk("sr_rd_ack", ack, 1);
    for (int i = 0; i < 4; i++) slot(1'b1, d);
    chk("sr_bit3_drive", sda_low, 1);
    start_det = 1'b1; scl_fall = 1'b1; tick(1); start_det = 1'b0; scl_fall = 1'b0;
    chk("sr_sda_release", sda_low, 0);
    chk("sr_state_addr1", state_onehot, ST_ADDR1);
    tx_exp++;
    send_byte(8'hF5, ack); chk("sr_armed_kept", ack, 1);
    stop_cond();
    start_cond();
    send_byte(8'hF5, ack); chk("sr_unarmed_nack", ack, 0);
    chk("sr_unarmed_wait", state_onehot, ST_WAIT_STOP);
    stop_cond();

    // enable drop while transmitting a 0 bit, then mid-byte while receiving
    tx_exp++;
    start_cond();
    send_byte(8'h75, ack);
    slot(1'b1, d); slot(1'b1, d);
    chk("en_tx_drive", sda_low, 1);
    enable = 1'b0; tick(1);
    chk("en_tx_release", sda_low, 0);
    chk("en_tx_idle", state_onehot, ST_IDLE);
    enable = 1'b1;
    start_cond();
    send_byte(8'h74, ack);
    for (int i = 0; i < 4; i++) slot(1'b0, d);
    enable = 1'b0; tick(1);
    chk("en_rx_busy", busy, 0);
    for (int i = 0; i < 4; i++) slot(1'b0, d);
    enable = 1'b1; tick(2);

    chk("end_rx_count", rx_seen, 3);
    chk("end_rx_queue", rx_q.size(), 0);
    chk("end_tx_count", tx_seen, tx_exp);
    chk("end_no_timeout", to_main, 0);
    chk("end_t_rx_count", t_rx_seen, 3);
    chk("end_t_tx_count", t_tx_seen, tx_exp - 1);
    chk("end_t_rx_byte", t_rx_byte, 8'h22);
    chk("end_t_state", t_state_onehot, ST_IDLE);
    chk("end_t_match_sda", {t_match_idx, t_sda_low}, {2'b01, 1'b0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
